bitsel_sweep_ctrl: RTL
======================

// Module: bitsel_sweep_ctrl
// PURPOSE
//   Sequencer for one shared dynamic bit-select unit. Accepts a source vector over a
//   valid/ready handshake and drives the select index through every value 0..2**SELW-1,
//   one index per clock. Packs the selected bits, plus a mask of out-of-range indices,
//   into one result word. Sits in front of the FROMW-bit select datapath and gives it
//   defined out-of-range behaviour: those bits read as 0 and set a flag, never X.
// PARAMETERS
//   FROMW  7  width of the source vector (legal indices 0..FROMW-1), 1..64
//   SELW   3  select-index width, 1..6; sweep length N = 2**SELW
// PORTS
//   clk           in   1      single clock, rising edge
//   rst_n         in   1      asynchronous, active-low reset
//   start_valid   in   1      request carries a new source vector
//   start_ready   out  1      controller accepts a request (high only in IDLE)
//   start_vec     in   FROMW  source vector, sampled on the accept edge only
//   abort         in   1      synchronous cancel of an in-progress sweep
//   busy          out  1      high in SWEEP
//   sel_idx       out  SELW   current index presented to the select unit
//   result_valid  out  1      result word available (high only in DONE)
//   result_ready  in   1      consumer takes the result
//   result_bits   out  N      bit i = start_vec[i] if i<FROMW, else 0
//   result_oor    out  N      bit i = 1 iff i>=FROMW (out of range)
// BEHAVIOUR
//   - Reset: state=IDLE; sel_idx, result_bits, result_oor all 0; result_valid=0;
//     busy=0; start_ready=1 as soon as rst_n deasserts. The latched vector is cleared.
//   - FSM IDLE -> SWEEP -> DONE -> IDLE. There are no other states; illegal encodings
//     return to IDLE.
//   - IDLE: accept edge = start_valid & start_ready. On it: latch start_vec, idx<=0,
//     clear result_bits and result_oor, go to SWEEP.
//   - SWEEP, each edge:
//     - result_bits[idx] <= (idx<FROMW) ? vec[idx] : 0
//     - result_oor[idx] <= (idx>=FROMW)
//     - idx <= idx+1
//     - the edge with idx==N-1 goes to DONE; idx wraps to 0 and does not saturate.
//   - Index compare uses an unsigned index zero-extended to 7 bits against FROMW,
//     so the compare never truncates for any legal parameters.
//   - Latency: exactly N SWEEP edges. result_valid is first high in the cycle after
//     the N-th edge following the accept edge.
//   - DONE: result_bits and result_oor are held stable while result_valid=1. When
//     result_ready=1, go to IDLE and drop result_valid. start_ready is still 0 in
//     DONE, so no same-cycle restart: min request-to-request spacing is N+2 cycles.
//   - abort:
//     - in SWEEP: go to IDLE on that edge; no result is produced; partial bits are
//       cleared.
//     - ignored in IDLE and in DONE, where a finished result is never discarded.
//     - abort on the same edge as the final SWEEP edge: abort wins, state goes to
//       IDLE, no result_valid.
//   - start_valid outside IDLE is ignored; the requester holds it until start_ready.
//   - Reset mid-operation (any state): immediate return to reset values; no partial
//     result is ever presented.
//   - sel_idx = idx register; it equals 0 outside SWEEP.
//   - FROMW >= N: result_oor stays all-zero. FROMW=1, SELW=1: result_bits =
//     {0, vec[0]}, result_oor = 2'b10.
// STRUCTURE
//   - Package bitsel_sweep_pkg: state enum (IDLE/SWEEP/DONE, 2-bit) and function
//     sweep_len(SELW) = 1<<SELW.
//   - One sub-module, bitsel_lane: combinational {bit, oor} = select(vec, idx, FROMW).
//     It is the shared datapath the controller sequences.
//   - Top holds the FSM, index counter and result/oor registers with per-bit write
//     enable decoded from idx.
// TESTING
//   1. FROMW=7, SELW=3, vec=7'b1010011 -> result_bits=8'b01010011,
//      result_oor=8'b10000000, result_valid exactly 8 cycles after accept.
//   2. Back-pressure: hold result_ready=0 for 5 cycles -> outputs stable,
//      start_ready=0 throughout. Then raise result_ready -> IDLE next edge,
//      start_ready=1.
//   3. abort when sel_idx=3 -> IDLE next edge, result_valid never rises,
//      result_bits=0. A following request vec=7'h7F -> result_bits=8'h7F.
//   4. abort together with the final sweep edge (sel_idx=7) -> IDLE, no result.
//      abort in DONE -> result kept and delivered.
//   5. rst_n low mid-SWEEP (sel_idx=5) -> all outputs 0 immediately, start_ready=1
//      after release, next sweep correct.
//   6. Parameter sweep: FROMW in {1,2,5,7}, SELW in {1..6}, random vec -> match
//      reference model, including all-ones/all-zeros vec and back-to-back requests.

Source files
------------

// File: rtl/bitsel_sweep_pkg.sv
// rtl/bitsel_sweep_pkg.sv - shared types and helpers for the bit-select sweep controller
package bitsel_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int sweep_len(input int selw);
    return 1 << selw;
  endfunction

endpackage

// File: rtl/bitsel_sweep_ctrl_if.sv
// rtl/bitsel_sweep_ctrl_if.sv - request/result handshake bundle for the sweep controller
interface bitsel_sweep_ctrl_if #(
  parameter int FROMW = 7,
  parameter int SELW  = 3
);
  import bitsel_sweep_pkg::*;

  localparam int N = sweep_len(SELW);

  logic             start_valid;
  logic             start_ready;
  logic [FROMW-1:0] start_vec;
  logic             abort;
  logic             busy;
  logic [SELW-1:0]  sel_idx;
  logic             result_valid;
  logic             result_ready;
  logic [N-1:0]     result_bits;
  logic [N-1:0]     result_oor;

  modport master (
    output start_valid, start_vec, abort, result_ready,
    input  start_ready, busy, sel_idx, result_valid, result_bits, result_oor
  );

  modport slave (
    input  start_valid, start_vec, abort, result_ready,
    output start_ready, busy, sel_idx, result_valid, result_bits, result_oor
  );

endinterface

// File: rtl/bitsel_lane.sv
// rtl/bitsel_lane.sv - shared select datapath: one bit of vec at idx, zero and flagged when out of range
module bitsel_lane #(
  parameter int FROMW = 7,
  parameter int SELW  = 3
) (
  input  logic [FROMW-1:0] vec,
  input  logic [SELW-1:0]  idx,
  output logic             sel_bit,
  output logic             oor
);

  // 7-bit compare covers FROMW up to 64 and SELW up to 6 without truncation
  logic [6:0] idx_ext;

  always_comb begin
    idx_ext = 7'(idx);
    oor     = (idx_ext >= 7'(FROMW));
    sel_bit = 1'b0;
    for (int i = 0; i < FROMW; i++) begin
      if (idx_ext == 7'(i)) sel_bit = vec[i];
    end
  end

endmodule

// File: rtl/bitsel_sweep_ctrl.sv
// rtl/bitsel_sweep_ctrl.sv - sweeps sel_idx over 0..2**SELW-1 and packs selected bits and oor flags
module bitsel_sweep_ctrl
  import bitsel_sweep_pkg::*;
#(
  parameter int FROMW = 7,
  parameter int SELW  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  bitsel_sweep_ctrl_if.slave bus
);

  localparam int N = sweep_len(SELW);

  state_e           state_q, state_d;
  logic [FROMW-1:0] vec_q;
  logic [SELW-1:0]  idx_q;
  logic [N-1:0]     bits_q, oor_q, wr_en;
  logic             lane_bit, lane_oor;

  bitsel_lane #(.FROMW(FROMW), .SELW(SELW)) u_lane (
    .vec     (vec_q),
    .idx     (idx_q),
    .sel_bit (lane_bit),
    .oor     (lane_oor)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_valid) state_d = SWEEP;
      SWEEP:   if (bus.abort) state_d = IDLE;
               else if (idx_q == SELW'(N - 1)) state_d = DONE;
      DONE:    if (bus.result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // abort suppresses the write so the final-edge abort leaves no partial result
  always_comb begin
    wr_en = '0;
    if (state_q == SWEEP && !bus.abort) wr_en[idx_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q  <= '0;
      idx_q  <= '0;
      bits_q <= '0;
      oor_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid) begin
            vec_q  <= bus.start_vec;
            idx_q  <= '0;
            bits_q <= '0;
            oor_q  <= '0;
          end
        end
        SWEEP: begin
          if (bus.abort) begin
            vec_q  <= '0;
            idx_q  <= '0;
            bits_q <= '0;
            oor_q  <= '0;
          end else begin
            idx_q  <= idx_q + SELW'(1);
            bits_q <= (bits_q & ~wr_en) | ({N{lane_bit}} & wr_en);
            oor_q  <= (oor_q & ~wr_en) | ({N{lane_oor}} & wr_en);
          end
        end
        DONE: begin
        end
        default: begin
          vec_q  <= '0;
          idx_q  <= '0;
          bits_q <= '0;
          oor_q  <= '0;
        end
      endcase
    end
  end

  assign bus.start_ready  = (state_q == IDLE);
  assign bus.busy         = (state_q == SWEEP);
  assign bus.result_valid = (state_q == DONE);
  assign bus.sel_idx      = idx_q;
  assign bus.result_bits  = bits_q;
  assign bus.result_oor   = oor_q;

endmodule
